sqrt_recon: RTL and testbench

- Multi-cycle inverse of the ALU integer square-root unit: takes a root/remainder pair (q, r) and reconstructs the radicand as out = q*q + r.
- Sits beside the sqrt unit in the ALU. Used as a self-check and wherever a value held in root form must be expanded back to full width.
- Uses an iterative shift-add squarer with a start/busy/done handshake. Also flags remainders that the sqrt unit could not have produced (r > 2q).

---
 rtl/sqrt_recon_pkg.sv | 18 +
 rtl/sqrt_recon_if.sv | 29 ++
 rtl/sqrt_recon_step.sv | 36 +++
 rtl/sqrt_recon.sv | 131 +++++++++++++
 tb/tb_sqrt_recon.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/sqrt_recon_pkg.sv
// Shared ALU definitions for the square-root pair: FSM state codes and the
// default operand widths used by both the sqrt unit and sqrt_recon.
package sqrt_recon_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int INLEN = 32;
   localparam int QLEN  = INLEN / 2;
   localparam int RLEN  = INLEN / 2 + 1;

   // Bit count of the CALC counter; it must be able to hold qLen itself.
   function automatic int cnt_width(input int q_len);
      return $clog2(q_len) + 1;
   endfunction

endpackage

// File: rtl/sqrt_recon_if.sv
// Request/result bundle for sqrt_recon.
// Handshake: the master raises start with q_in/r_in valid while busy is low;
// the slave captures them on that edge, holds busy until its one-cycle done
// pulse ends, and keeps out/rem_err stable from done until the next done.
interface sqrt_recon_if #(
   parameter int inLen = sqrt_recon_pkg::INLEN,
   parameter int qLen  = inLen / 2,
   parameter int rLen  = inLen / 2 + 1
);

   logic             start;
   logic [qLen-1:0]  q_in;
   logic [rLen-1:0]  r_in;
   logic [inLen-1:0] out;
   logic             rem_err;
   logic             busy;
   logic             done;

   modport master (
      output start, q_in, r_in,
      input  out, rem_err, busy, done
   );

   modport slave (
      input  start, q_in, r_in,
      output out, rem_err, busy, done
   );

endinterface

// File: rtl/sqrt_recon_step.sv
// One CALC step of the shift-add squarer: adds the partial product(s) of q
// selected by the current bit index. Two bits per step when
// SQRT_RECON_RADIX4_EN is defined, one bit otherwise.
module sqrt_recon_step #(
   parameter int inLen = 32,
   parameter int qLen  = inLen / 2,
   parameter int CW    = 5
) (
   input  logic [inLen-1:0] acc_in,
   input  logic [qLen-1:0]  q_in,
   input  logic [CW-1:0]    idx,
   output logic [inLen-1:0] acc_out
);

   logic [inLen-1:0] q_ext;
   logic             bit0;
   logic [inLen-1:0] pp0;

   assign q_ext = inLen'(q_in);
   assign bit0  = |(q_ext & (inLen'(1) << idx));
   assign pp0   = bit0 ? (q_ext << idx) : '0;

`ifdef SQRT_RECON_RADIX4_EN
   logic [CW-1:0]    idx1;
   logic             bit1;
   logic [inLen-1:0] pp1;

   assign idx1    = idx + CW'(1);
   assign bit1    = |(q_ext & (inLen'(1) << idx1));
   assign pp1     = bit1 ? (q_ext << idx1) : '0;
   assign acc_out = acc_in + pp0 + pp1;
`else
   assign acc_out = acc_in + pp0;
`endif

endmodule

// File: rtl/sqrt_recon.sv
// Reconstructs a radicand from a root/remainder pair: out = q*q + r, and flags
// remainders above 2q. Optional macro: SQRT_RECON_RADIX4_EN (two q bits/cycle).
module sqrt_recon
   import sqrt_recon_pkg::*;
#(
   parameter int inLen = INLEN,
   parameter int qLen  = inLen / 2,
   parameter int rLen  = inLen / 2 + 1
) (
   input  logic             clk,
   input  logic             reset,
   sqrt_recon_if.slave      bus,
   output logic [1:0]       dbg_state
);

   localparam int CW = cnt_width(qLen);

`ifdef SQRT_RECON_RADIX4_EN
   localparam logic [CW-1:0] STEP = CW'(2);
   localparam logic [CW-1:0] LAST = CW'(qLen - 2);
`else
   localparam logic [CW-1:0] STEP = CW'(1);
   localparam logic [CW-1:0] LAST = CW'(qLen - 1);
`endif

   logic [1:0]       state_q,   state_d;
   logic [CW-1:0]    cnt_q,     cnt_d;
   logic [inLen-1:0] acc_q,     acc_d;
   logic [qLen-1:0]  q_reg_q,   q_reg_d;
   logic [rLen-1:0]  r_reg_q,   r_reg_d;
   logic [inLen-1:0] out_q,     out_d;
   logic             rem_err_q, rem_err_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;

   logic [inLen-1:0] acc_step;
   logic [rLen:0]    r_wide;
   logic [rLen:0]    q_twice;

   sqrt_recon_step #(
      .inLen (inLen),
      .qLen  (qLen),
      .CW    (CW)
   ) u_step (
      .acc_in  (acc_q),
      .q_in    (q_reg_q),
      .idx     (cnt_q),
      .acc_out (acc_step)
   );

   // One extra bit on both sides so 2q cannot wrap in the compare.
   assign r_wide  = (rLen + 1)'(r_reg_q);
   assign q_twice = (rLen + 1)'(q_reg_q) << 1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      q_reg_d   = q_reg_q;
      r_reg_d   = r_reg_q;
      out_d     = out_q;
      rem_err_d = rem_err_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      // busy stays up through the done cycle, which also blocks a start there.
      if (done_q) begin
         busy_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (bus.start && !busy_q) begin
               q_reg_d = bus.q_in;
               r_reg_d = bus.r_in;
               acc_d   = inLen'(bus.r_in);
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d = acc_step;
            cnt_d = cnt_q + STEP;
            if (cnt_q == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_d     = acc_q;
            rem_err_d = (r_wide > q_twice);
            done_d    = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         q_reg_q   <= '0;
         r_reg_q   <= '0;
         out_q     <= '0;
         rem_err_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         q_reg_q   <= q_reg_d;
         r_reg_q   <= r_reg_d;
         out_q     <= out_d;
         rem_err_q <= rem_err_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign bus.out     = out_q;
   assign bus.rem_err = rem_err_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_sqrt_recon.sv
// Scoreboard bench for sqrt_recon: directed corner cases, randomized (q,r)
// pairs and a round trip through a behavioural integer square root.
module tb_sqrt_recon;
   import sqrt_recon_pkg::*;

`ifdef SQRT_RECON_RADIX4_EN
   localparam int LAT = QLEN / 2 + 2;
`else
   localparam int LAT = QLEN + 2;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] dbg_state;

   sqrt_recon_if #(.inLen(INLEN)) bus ();

   sqrt_recon #(.inLen(INLEN)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [INLEN:0] exp_q[$];
   int             acc_cyc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference: plain arithmetic on the operands.
   function automatic logic [INLEN:0] model(input logic [QLEN-1:0] q, input logic [RLEN-1:0] r);
      longint unsigned s;
      logic            err;
      s   = longint'(q) * longint'(q) + longint'(r);
      err = longint'(r) > 2 * longint'(q);
      return {err, s[INLEN-1:0]};
   endfunction

   // Stand-in for the sqrt unit: floor square root by bitwise trial.
   function automatic logic [QLEN-1:0] isqrt(input logic [INLEN-1:0] v);
      longint unsigned res = 0;
      longint unsigned t;
      for (int b = QLEN - 1; b >= 0; b--) begin
         t = res | (longint'(1) << b);
         if (t * t <= longint'(v)) res = t;
      end
      return res[QLEN-1:0];
   endfunction

   // Monitor: every done must match the oldest expected result and latency.
   always @(negedge clk) begin
      if (!reset && bus.done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'(bus.out), 64'hDEAD);
         end else begin
            logic [INLEN:0] e;
            int             a;
            e = exp_q.pop_front();
            a = acc_cyc_q.pop_front();
            check("out", 64'(bus.out), 64'(e[INLEN-1:0]));
            check("rem_err", 64'(bus.rem_err), 64'(e[INLEN]));
            check("latency", 64'(cyc - a + 1), 64'(LAT));
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (bus.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) check("wait_idle_timeout", 64'(bus.busy), 64'd0);
   endtask

   task automatic issue(input logic [QLEN-1:0] q, input logic [RLEN-1:0] r,
                        input logic [INLEN:0] exp);
      wait_idle();
      bus.q_in  = q;
      bus.r_in  = r;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back(exp);
      acc_cyc_q.push_back(cyc);
      bus.start = 1'b0;
      bus.q_in  = QLEN'($urandom);
      bus.r_in  = RLEN'($urandom);
   endtask

   // Waits for done with busy held; poke=1 raises start during the done cycle.
   task automatic finish_op(input bit poke);
      int n = 0;
      bit busy_ok = 1'b1;
      @(negedge clk);
      while (!bus.done && n < LAT + 10) begin
         if (!bus.busy) busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      if (!bus.done) begin
         check("done_timeout", 64'(bus.done), 64'd1);
      end else begin
         check("busy_held", 64'(busy_ok && bus.busy), 64'd1);
         if (poke) begin
            bus.q_in  = QLEN'(7);
            bus.r_in  = '0;
            bus.start = 1'b1;
         end
         @(negedge clk);
         bus.start = 1'b0;
         check("done_pulse", 64'(bus.done), 64'd0);
         check("busy_fall", 64'(bus.busy), 64'd0);
      end
   endtask

   task automatic run_op(input logic [QLEN-1:0] q, input logic [RLEN-1:0] r);
      issue(q, r, model(q, r));
      finish_op(1'b0);
   endtask

   initial begin
      logic [INLEN-1:0] v;
      logic [QLEN-1:0]  q;
      logic [RLEN-1:0]  r;
      logic [INLEN-1:0] sweep[$];

      bus.start = 1'b0;
      bus.q_in  = '0;
      bus.r_in  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out", 64'(bus.out), 64'd0);
      check("rst_rem_err", 64'(bus.rem_err), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_state", 64'(dbg_state), 64'(IDLE));
      reset = 1'b0;

      // Directed corners
      issue(QLEN'(3), RLEN'(2), {1'b0, 32'd11});
      finish_op(1'b0);
      issue(QLEN'(16'hFFFF), RLEN'(17'h1FFFE), {1'b0, 32'hFFFF_FFFF});
      finish_op(1'b0);
      issue(QLEN'(3), RLEN'(7), {1'b1, 32'd16});
      finish_op(1'b0);
      issue(QLEN'(0), RLEN'(1), {1'b1, 32'd1});
      finish_op(1'b0);
      issue(QLEN'(0), RLEN'(17'h1FFFF), {1'b1, 32'h1FFFF});
      finish_op(1'b0);

      // start during CALC is dropped; start during the done cycle is dropped
      issue(QLEN'(5), RLEN'(0), {1'b0, 32'd25});
      repeat (4) @(negedge clk);
      bus.q_in  = QLEN'(9);
      bus.r_in  = '0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      finish_op(1'b1);
      issue(QLEN'(9), RLEN'(0), {1'b0, 32'd81});
      finish_op(1'b0);

      // Reset in the middle of CALC
      issue(QLEN'(200), RLEN'(3), model(QLEN'(200), RLEN'(3)));
      repeat (7) @(negedge clk);
      exp_q.delete();
      acc_cyc_q.delete();
      reset = 1'b1;
      @(negedge clk);
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_done", 64'(bus.done), 64'd0);
      check("midrst_out", 64'(bus.out), 64'd0);
      check("midrst_state", 64'(dbg_state), 64'(IDLE));
      reset = 1'b0;
      issue(QLEN'(4), RLEN'(1), {1'b0, 32'd17});
      finish_op(1'b0);

      // Random pairs, valid and invalid remainders
      for (int i = 0; i < 60; i++) begin
         q = QLEN'($urandom);
         if (i % 2 == 0) r = RLEN'($urandom_range(0, 2 * int'(q)));
         else            r = RLEN'($urandom);
         run_op(q, r);
      end

      // Round trip through the behavioural sqrt: out must equal the radicand
      for (int i = 0; i < 64; i++) sweep.push_back(INLEN'(i));
      sweep.push_back(32'd65535);
      sweep.push_back(32'd65536);
      sweep.push_back(32'hFFFE_0001);
      sweep.push_back(32'hFFFF_FFFF);
      for (int i = 0; i < 40; i++) sweep.push_back(INLEN'($urandom));
      foreach (sweep[i]) begin
         v = sweep[i];
         q = isqrt(v);
         r = RLEN'(v - INLEN'(q) * INLEN'(q));
         issue(q, r, {1'b0, v});
         finish_op(1'b0);
      end

      repeat (LAT + 5) @(negedge clk);
      check("queue_drain", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
